marsohod_key_reset_ctrl: RTL and testbench



---
 rtl/marsohod_key_reset_ctrl.sv | 171 +++++++++++++++++
 tb/tb_marsohod_key_reset_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/marsohod_key_reset_ctrl.sv
// marsohod_key_reset_ctrl
// Conditions the raw KEY0 button of the Marsohod2bis board: two-flop
// synchroniser, debounce FSM with press/release/long-press pulses, and a
// stretched registered active-low reset for the clock generator.
//
// Build option: define KEY_RESET_LONG_PRESS_EN to make the reset stretcher
// fire only on a long press. When it is not defined, the debounced key level
// holds reset for the whole press plus the stretch window after release.
module marsohod_key_reset_ctrl #(
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int LONG_PRESS_CYCLES  = 200000000,
    parameter int RST_STRETCH_CYCLES = 1024
) (
    input  logic sys_clk_pad_i,
    input  logic rst_n_pad_i,
    input  logic key_n_i,
    output logic rst_n_o,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o,
    output logic long_press_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int ST_W   = $clog2(RST_STRETCH_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [ST_W-1:0]   ST_LOAD  = ST_W'(RST_STRETCH_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_e;

    logic              sync1_q;
    logic              sync2_q;
    logic              key_s;
    state_e            state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              rst_trig;
    logic [ST_W-1:0]   st_cnt_q;
    logic [ST_W-1:0]   st_d;
    logic              rst_n_q;

    // Two-flop synchroniser for the asynchronous key; idles at released (1).
    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let sync2_q take the old sync1_q,
            // giving a real two-stage pipeline; blocking would collapse it.
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = sync2_q;

    // Debounce FSM with hold counter and registered single-cycle event pulses.
    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; a later assignment in the
            // same block overrides, so each event lasts exactly one cycle.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            // Hold time keeps running through release debounce, saturating.
            if ((state_q == ST_PRESSED || state_q == ST_DB_RELEASE) &&
                (hold_cnt_q != HOLD_MAX)) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_MAX - 1'b1) begin
                    long_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (!key_s) begin
                        state_q  <= ST_DB_PRESS;
                        db_cnt_q <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (key_s) begin
                        state_q <= ST_IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= ST_PRESSED;
                        press_q    <= 1'b1;
                        level_q    <= 1'b1;
                        hold_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (key_s) begin
                        state_q  <= ST_DB_RELEASE;
                        db_cnt_q <= '0;
                    end
                end
                ST_DB_RELEASE: begin
                    if (!key_s) begin
                        state_q <= ST_PRESSED;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= ST_IDLE;
                        release_q  <= 1'b1;
                        level_q    <= 1'b0;
                        hold_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef KEY_RESET_LONG_PRESS_EN
    assign rst_trig = long_q;
`else
    assign rst_trig = level_q;
`endif

    // Stretcher next count: reload on trigger, otherwise count down to zero.
    always_comb begin
        // NOTE: default first so every path assigns st_d and no latch is inferred.
        st_d = st_cnt_q;
        if (rst_trig) begin
            st_d = ST_LOAD;
        end else if (st_cnt_q != '0) begin
            st_d = st_cnt_q - 1'b1;
        end
    end

    // Stretcher state and glitch-free registered reset output.
    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            st_cnt_q <= ST_LOAD;
            rst_n_q  <= 1'b0;
        end else begin
            st_cnt_q <= st_d;
            rst_n_q  <= (st_d == '0);
        end
    end

    assign rst_n_o       = rst_n_q;
    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign long_press_o  = long_q;

endmodule

// File: tb/tb_marsohod_key_reset_ctrl.sv
// Testbench for marsohod_key_reset_ctrl. A run-length reference model predicts
// every output each clock; a monitor on the falling edge pops and compares.
// Honours KEY_RESET_LONG_PRESS_EN the same way the design does.
module tb_marsohod_key_reset_ctrl;

    localparam int D = 8;
    localparam int L = 32;
    localparam int S = 4;

    typedef struct packed {
        logic rstn;
        logic lvl;
        logic prs;
        logic rel;
        logic lng;
    } out_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic key_n = 1'b1;
    logic rst_n_o, key_level, key_press, key_release, long_press;

    int checks = 0;
    int errors = 0;

    marsohod_key_reset_ctrl #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .RST_STRETCH_CYCLES(S)
    ) dut (
        .sys_clk_pad_i(clk),
        .rst_n_pad_i  (rst_n),
        .key_n_i      (key_n),
        .rst_n_o      (rst_n_o),
        .key_level_o  (key_level),
        .key_press_o  (key_press),
        .key_release_o(key_release),
        .long_press_o (long_press)
    );

    always #5 clk = ~clk;

    // Reference model state.
    out_t exp_q[$];
    logic hist[$];
    int   m_cyc, m_run, m_since, m_last_trig;
    logic m_level, m_long, m_s, m_trig, m_prs, m_rel, m_lng;
    bit   mon_en = 1'b0;
    out_t m_exp;

    // Model: key accepted after D+1 consecutive opposite synchronised samples;
    // long press L cycles after press; reset high once S edges pass a trigger.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            hist.push_back(1'b1);
            hist.push_back(1'b1);
            m_cyc = 0; m_run = 0; m_since = 0; m_last_trig = 0;
            m_level = 1'b0; m_long = 1'b0;
            exp_q.delete();
            exp_q.push_back(out_t'(5'b0));
            mon_en = 1'b1;
        end else begin
            m_cyc++;
            m_s = hist.pop_front();
            hist.push_back(key_n);
`ifdef KEY_RESET_LONG_PRESS_EN
            m_trig = m_long;
`else
            m_trig = m_level;
`endif
            if (m_trig) m_last_trig = m_cyc;
            m_prs = 1'b0; m_rel = 1'b0; m_lng = 1'b0;
            if (m_level) begin
                m_since++;
                if (m_since == L) m_lng = 1'b1;
            end
            if ((~m_s) != m_level) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_run = 0;
                if (m_level) m_rel = 1'b1;
                else begin
                    m_prs = 1'b1;
                    m_since = 0;
                end
                m_level = ~m_level;
            end
            m_long = m_lng;
            m_exp.rstn = ((m_cyc - m_last_trig) >= S);
            m_exp.lvl  = m_level;
            m_exp.prs  = m_prs;
            m_exp.rel  = m_rel;
            m_exp.lng  = m_lng;
            exp_q.push_back(m_exp);
        end
    end

    // Monitor: compare DUT outputs with the oldest prediction on each falling edge.
    always @(negedge clk) begin
        out_t got, e;
        if (mon_en) begin
            got = {rst_n_o, key_level, key_press, key_release, long_press};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty @%0t: got %b, no prediction", $time, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t (rstn,lvl,prs,rel,lng): got %b expected %b",
                             $time, got, e);
                end
            end
        end
    end

    task automatic drive_key(input logic lvl, input int n);
        key_n = lvl;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic lvl;
        int   n;
        step(3);
        rst_n = 1'b1;
        drive_key(1'b1, 10);                       // power-on stretch window
        drive_key(1'b0, 20); drive_key(1'b1, 20);  // clean press
        drive_key(1'b0, 5);  drive_key(1'b1, 20);  // short glitch
        drive_key(1'b0, 20); drive_key(1'b1, 3);   // bounce inside a press
        drive_key(1'b0, 20); drive_key(1'b1, 20);
        drive_key(1'b0, 60); drive_key(1'b1, 20);  // long press
        drive_key(1'b0, 6);                        // reset while debouncing
        rst_n = 1'b0;
        key_n = 1'b1;
        step(3);
        rst_n = 1'b1;
        drive_key(1'b1, 20);
        for (int i = 0; i < 80; i++) begin
            lvl = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 70))
                                            : int'($urandom_range(1, 14));
            drive_key(lvl, n);
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                step(int'($urandom_range(1, 3)));
                rst_n = 1'b1;
            end
        end
        drive_key(1'b1, 30);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
